// File: rtl/fft_peak_picker_if.sv
// Stream and result bundle between the FFT output, the peak picker and the
// pitch/transcription logic. "slave" is the peak picker side.
interface fft_peak_picker_if #(
   parameter int BIN_W = 12
);
   logic [15:0]      fft_data_in;
   logic             fft_valid_in;
   logic             fft_last_in;
   logic             fft_ready_out;
   logic [BIN_W-1:0] peak_bin_out;
   logic [15:0]      peak_mag_out;
   logic             peak_valid_out;
   logic             note_on_out;
   logic             frame_err_out;

   modport slave (
      input  fft_data_in, fft_valid_in, fft_last_in,
      output fft_ready_out, peak_bin_out, peak_mag_out,
             peak_valid_out, note_on_out, frame_err_out
   );

   modport master (
      output fft_data_in, fft_valid_in, fft_last_in,
      input  fft_ready_out, peak_bin_out, peak_mag_out,
             peak_valid_out, note_on_out, frame_err_out
   );
endinterface

// File: rtl/fft_peak_picker.sv
// Squared-magnitude peak search over one FFT frame. Bins stream in one per
// beat, pass a 3-stage square/sum pipeline, and the strongest in-window bin
// is reported 4 cycles after the end-of-frame handshake.
module fft_peak_picker #(
   parameter int          NFFT    = 4096,
   parameter int          BIN_W   = 12,
   parameter int          MIN_BIN = 1,
   parameter int          MAX_BIN = 2047,
   parameter logic [15:0] THRESH  = 16'd256
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
   fft_peak_picker_if.slave bus
);
   localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NFFT - 1);
   localparam logic [BIN_W-1:0] MIN_B    = BIN_W'(MIN_BIN);
   localparam logic [BIN_W-1:0] MAX_B    = BIN_W'(MAX_BIN);

   typedef enum logic [1:0] {ACCUM, FLUSH, REPORT} state_t;

   state_t             state_q, state_d;
   logic [1:0]         flush_cnt_q, flush_cnt_d;
   logic               ready_q, ready_d;
   logic [BIN_W-1:0]   bin_cnt_q, bin_cnt_d;
   logic               err_pend_q, err_pend_d;

   logic               s1_valid_q, s1_valid_d;
   logic signed [7:0]  s1_re_q, s1_re_d;
   logic signed [7:0]  s1_im_q, s1_im_d;
   logic [BIN_W-1:0]   s1_tag_q, s1_tag_d;
   logic               s2_valid_q, s2_valid_d;
   logic [14:0]        s2_re_sq_q, s2_re_sq_d;
   logic [14:0]        s2_im_sq_q, s2_im_sq_d;
   logic [BIN_W-1:0]   s2_tag_q, s2_tag_d;
   logic               s3_valid_q, s3_valid_d;
   logic [15:0]        s3_sum_q, s3_sum_d;
   logic [BIN_W-1:0]   s3_tag_q, s3_tag_d;

   logic [15:0]        best_mag_q, best_mag_d;
   logic [BIN_W-1:0]   best_bin_q, best_bin_d;

   logic [BIN_W-1:0]   peak_bin_q, peak_bin_d;
   logic [15:0]        peak_mag_q, peak_mag_d;
   logic               peak_valid_q, peak_valid_d;
   logic               note_on_q, note_on_d;
   logic               frame_err_q, frame_err_d;

   logic               accept;
   logic               at_last_bin;
   logic               eof;

   assign accept      = ready_q && bus.fft_valid_in;
   assign at_last_bin = (bin_cnt_q == LAST_BIN);
   assign eof         = accept && (bus.fft_last_in || at_last_bin);

   // Next-state logic: pipeline, bin tagging, best tracking and frame FSM.
   always_comb begin
      state_d      = state_q;
      flush_cnt_d  = flush_cnt_q;
      bin_cnt_d    = bin_cnt_q;
      err_pend_d   = err_pend_q;
      best_mag_d   = best_mag_q;
      best_bin_d   = best_bin_q;
      peak_bin_d   = peak_bin_q;
      peak_mag_d   = peak_mag_q;
      peak_valid_d = 1'b0;
      note_on_d    = note_on_q;
      frame_err_d  = frame_err_q;

      // Pipeline moves every cycle; bubbles carry valid=0.
      s1_valid_d = accept;
      s1_re_d    = bus.fft_data_in[7:0];
      s1_im_d    = bus.fft_data_in[15:8];
      s1_tag_d   = bin_cnt_q;
      s2_valid_d = s1_valid_q;
      s2_re_sq_d = 15'(s1_re_q) * 15'(s1_re_q);
      s2_im_sq_d = 15'(s1_im_q) * 15'(s1_im_q);
      s2_tag_d   = s1_tag_q;
      s3_valid_d = s2_valid_q;
      s3_sum_d   = {1'b0, s2_re_sq_q} + {1'b0, s2_im_sq_q};
      s3_tag_d   = s2_tag_q;

      // Strict compare so that equal magnitudes keep the earlier (lower) bin.
      if (s3_valid_q && (s3_tag_q >= MIN_B) && (s3_tag_q <= MAX_B) &&
          (s3_sum_q > best_mag_q)) begin
         best_mag_d = s3_sum_q;
         best_bin_d = s3_tag_q;
      end

      if (accept) begin
         bin_cnt_d = eof ? '0 : bin_cnt_q + BIN_W'(1);
      end
      // A frame is malformed when last and the final bin index disagree.
      if (eof && (bus.fft_last_in != at_last_bin)) begin
         err_pend_d = 1'b1;
      end

      case (state_q)
         ACCUM: begin
            if (eof) begin
               state_d     = FLUSH;
               flush_cnt_d = 2'd0;
            end
         end
         FLUSH: begin
            if (flush_cnt_q == 2'd2) begin
               // The last beat sits in S3 now, so best_*_d already includes it.
               state_d      = REPORT;
               peak_bin_d   = best_bin_d;
               peak_mag_d   = best_mag_d;
               note_on_d    = (best_mag_d >= THRESH);
               frame_err_d  = err_pend_q;
               peak_valid_d = 1'b1;
            end else begin
               flush_cnt_d = flush_cnt_q + 2'd1;
            end
         end
         REPORT: begin
            state_d    = ACCUM;
            best_mag_d = '0;
            best_bin_d = MIN_B;
            err_pend_d = 1'b0;
         end
         default: state_d = ACCUM;
      endcase

      ready_d = (state_d == ACCUM);
   end

   // State, pipeline and output registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= ACCUM;
         flush_cnt_q  <= '0;
         ready_q      <= 1'b0;
         bin_cnt_q    <= '0;
         err_pend_q   <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_re_q      <= '0;
         s1_im_q      <= '0;
         s1_tag_q     <= '0;
         s2_valid_q   <= 1'b0;
         s2_re_sq_q   <= '0;
         s2_im_sq_q   <= '0;
         s2_tag_q     <= '0;
         s3_valid_q   <= 1'b0;
         s3_sum_q     <= '0;
         s3_tag_q     <= '0;
         best_mag_q   <= '0;
         best_bin_q   <= MIN_B;
         peak_bin_q   <= '0;
         peak_mag_q   <= '0;
         peak_valid_q <= 1'b0;
         note_on_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_cnt_q  <= flush_cnt_d;
         ready_q      <= ready_d;
         bin_cnt_q    <= bin_cnt_d;
         err_pend_q   <= err_pend_d;
         s1_valid_q   <= s1_valid_d;
         s1_re_q      <= s1_re_d;
         s1_im_q      <= s1_im_d;
         s1_tag_q     <= s1_tag_d;
         s2_valid_q   <= s2_valid_d;
         s2_re_sq_q   <= s2_re_sq_d;
         s2_im_sq_q   <= s2_im_sq_d;
         s2_tag_q     <= s2_tag_d;
         s3_valid_q   <= s3_valid_d;
         s3_sum_q     <= s3_sum_d;
         s3_tag_q     <= s3_tag_d;
         best_mag_q   <= best_mag_d;
         best_bin_q   <= best_bin_d;
         peak_bin_q   <= peak_bin_d;
         peak_mag_q   <= peak_mag_d;
         peak_valid_q <= peak_valid_d;
         note_on_q    <= note_on_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign bus.fft_ready_out  = ready_q;
   assign bus.peak_bin_out   = peak_bin_q;
   assign bus.peak_mag_out   = peak_mag_q;
   assign bus.peak_valid_out = peak_valid_q;
   assign bus.note_on_out    = note_on_q;
   assign bus.frame_err_out  = frame_err_q;
endmodule

// File: tb/tb_fft_peak_picker.sv
// Bench for fft_peak_picker: directed frames, a frame-level reference model
// checked every cycle, and literal expectations for each reported frame.
module tb_fft_peak_picker;
   logic clk = 1'b0;
   logic rst_n;

   fft_peak_picker_if #(.BIN_W(12)) bus ();

   fft_peak_picker #(
      .NFFT(4096), .BIN_W(12), .MIN_BIN(1), .MAX_BIN(2047), .THRESH(16'd256)
   ) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_print = 0;
   int dut_pulses = 0;

   logic [15:0] frame_data [4096];

   // Reference model state (frame-level view of the block).
   bit m_ready, m_pulse, m_acc, m_eof, m_err;
   int m_stall, m_cnt, m_mag, m_best_mag, m_best_bin;
   int pend_bin, pend_mag;
   bit pend_err;
   int out_bin, out_mag;
   bit out_note, out_err;

   function automatic void chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         if (n_print < 40)
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
         n_print++;
      end
   endfunction

   function automatic int mag_of(input logic [15:0] d);
      int re, im;
      re = $signed(d[7:0]);
      im = $signed(d[15:8]);
      return re * re + im * im;
   endfunction

   // Model: track the frame's best in-window bin and the stall/report timing.
   always @(posedge clk) begin
      m_pulse = 1'b0;
      if (!rst_n) begin
         m_ready = 1'b0; m_stall = 0; m_cnt = 0; m_err = 1'b0;
         m_best_mag = 0; m_best_bin = 1;
         out_bin = 0; out_mag = 0; out_note = 1'b0; out_err = 1'b0;
      end else begin
         m_acc = bus.fft_valid_in && m_ready;
         if (m_stall > 0) begin
            m_stall--;
            if (m_stall == 1) begin
               out_bin  = pend_bin;
               out_mag  = pend_mag;
               out_note = (pend_mag >= 256);
               out_err  = pend_err;
               m_pulse  = 1'b1;
            end
            if (m_stall == 0) m_ready = 1'b1;
         end else begin
            m_ready = 1'b1;
         end
         if (m_acc) begin
            m_mag = mag_of(bus.fft_data_in);
            if (m_cnt >= 1 && m_cnt <= 2047 && m_mag > m_best_mag) begin
               m_best_mag = m_mag;
               m_best_bin = m_cnt;
            end
            m_eof = bus.fft_last_in || (m_cnt == 4095);
            if (m_eof) begin
               pend_bin = m_best_bin;
               pend_mag = m_best_mag;
               pend_err = (bus.fft_last_in != (m_cnt == 4095));
               m_best_mag = 0; m_best_bin = 1; m_cnt = 0;
               m_stall = 4; m_ready = 1'b0;
            end else begin
               m_cnt++;
            end
         end
      end
   end

   // Compare every cycle, 1 time unit after the active edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         chk("ready",      int'(bus.fft_ready_out),  int'(m_ready));
         chk("peak_valid", int'(bus.peak_valid_out), int'(m_pulse));
         chk("peak_bin",   int'(bus.peak_bin_out),   out_bin);
         chk("peak_mag",   int'(bus.peak_mag_out),   out_mag);
         chk("note_on",    int'(bus.note_on_out),    int'(out_note));
         chk("frame_err",  int'(bus.frame_err_out),  int'(out_err));
         if (bus.peak_valid_out) dut_pulses++;
      end
   end

   task automatic clear_frame();
      for (int i = 0; i < 4096; i++) frame_data[i] = 16'h0000;
   endtask

   task automatic set_bin(input int idx, input int re, input int im);
      frame_data[idx] = {8'(im), 8'(re)};
   endtask

   // Drive nbeats beats; last_at < 0 means last is never asserted.
   task automatic send_frame(input int nbeats, input int last_at, input bit gate);
      int i = 0;
      int guard = 0;
      while (i < nbeats) begin
         @(negedge clk);
         bus.fft_valid_in = gate ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.fft_data_in  = frame_data[i];
         bus.fft_last_in  = (i == last_at);
         if (bus.fft_valid_in && bus.fft_ready_out) begin
            i++;
            guard = 0;
         end else begin
            guard++;
            if (guard > 64) begin
               chk("ready_timeout", 0, 1);
               break;
            end
         end
      end
      @(negedge clk);
      bus.fft_valid_in = 1'b0;
      bus.fft_last_in  = 1'b0;
      bus.fft_data_in  = 16'h0000;
   endtask

   // Wait for the report pulse, then pin latency, DUT outputs and model.
   task automatic expect_report(input string tag, input int e_bin, input int e_mag,
                                input bit e_note, input bit e_err);
      int k = 1;
      while (!bus.peak_valid_out && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({tag, ".latency"}, k, 4);
      chk({tag, ".bin"},  int'(bus.peak_bin_out),  e_bin);
      chk({tag, ".mag"},  int'(bus.peak_mag_out),  e_mag);
      chk({tag, ".note"}, int'(bus.note_on_out),   int'(e_note));
      chk({tag, ".err"},  int'(bus.frame_err_out), int'(e_err));
      chk({tag, ".model_bin"}, out_bin, e_bin);
      chk({tag, ".model_mag"}, out_mag, e_mag);
      $display("[TB] frame %s: bin=%0d mag=%0d note=%0d err=%0d latency=%0d",
               tag, bus.peak_bin_out, bus.peak_mag_out, bus.note_on_out,
               bus.frame_err_out, k);
      repeat (2) @(negedge clk);
   endtask

   task automatic tone_frame();
      clear_frame();
      set_bin(440, 100, 0);
   endtask

   initial begin
      int pulses_before;
      rst_n = 1'b0;
      bus.fft_valid_in = 1'b0;
      bus.fft_last_in  = 1'b0;
      bus.fft_data_in  = 16'h0000;
      repeat (3) @(negedge clk);
      chk("reset.ready", int'(bus.fft_ready_out), 0);
      chk("reset.mag",   int'(bus.peak_mag_out),  0);
      chk("reset.valid", int'(bus.peak_valid_out), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", int'(bus.fft_ready_out), 1);

      tone_frame();
      send_frame(4096, 4095, 1'b0);
      expect_report("tone", 440, 10000, 1'b1, 1'b0);

      clear_frame();
      set_bin(0, -128, -128);
      set_bin(3000, 60, 0);
      set_bin(200, 60, 0);
      set_bin(700, 60, 0);
      send_frame(4096, 4095, 1'b0);
      expect_report("window_tie", 200, 3600, 1'b1, 1'b0);

      clear_frame();
      set_bin(50, 10, 10);
      send_frame(4096, 4095, 1'b0);
      expect_report("below_thresh", 50, 200, 1'b0, 1'b0);

      clear_frame();
      send_frame(4096, 4095, 1'b0);
      expect_report("silence", 1, 0, 1'b0, 1'b0);

      clear_frame();
      set_bin(60, 60, 0);
      send_frame(101, 100, 1'b0);
      expect_report("early_last", 60, 3600, 1'b1, 1'b1);

      tone_frame();
      send_frame(4096, 4095, 1'b0);
      expect_report("after_err", 440, 10000, 1'b1, 1'b0);

      tone_frame();
      send_frame(4096, -1, 1'b0);
      expect_report("no_last", 440, 10000, 1'b1, 1'b1);

      tone_frame();
      send_frame(4096, 4095, 1'b1);
      expect_report("gated", 440, 10000, 1'b1, 1'b0);

      // Mid-frame reset: partial frame discarded, outputs cleared at once.
      pulses_before = dut_pulses;
      send_frame(1000, -1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midreset.mag",   int'(bus.peak_mag_out),  0);
      chk("midreset.bin",   int'(bus.peak_bin_out),  0);
      chk("midreset.note",  int'(bus.note_on_out),   0);
      chk("midreset.ready", int'(bus.fft_ready_out), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("midreset.no_pulse", dut_pulses, pulses_before);
      $display("[TB] mid-frame reset: pulses during abort=%0d", dut_pulses - pulses_before);

      tone_frame();
      send_frame(4096, 4095, 1'b0);
      expect_report("post_reset", 440, 10000, 1'b1, 1'b0);

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fft_peak_picker.md
# fft_peak_picker

Downstream stage of the 4096-point FFT. Consumes the FFT's AXI-Stream output one bin per beat, computes the squared magnitude of each bin, and tracks the strongest bin inside a configurable search window. At end of frame it reports the peak bin index, its magnitude, a note-present flag and a frame-error flag to the pitch/transcription logic.

## Interface
- `NFFT`, 4096, bins per frame; must be a power of two.
- `BIN_W`, 12, bin index width, equal to log2(NFFT).
- `MIN_BIN`, 1, lowest bin considered; excludes DC.
- `MAX_BIN`, 2047, highest bin considered; upper half is a mirror for real input.
- `THRESH`, 16'd256, minimum peak magnitude for `note_on_out`.

- `clk_in`  in  1  single clock for the block.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `fft_data_in`  in  16  FFT bin: `[7:0]` signed real, `[15:8]` signed imaginary.
- `fft_valid_in`  in  1  FFT beat valid.
- `fft_last_in`  in  1  last beat of the FFT frame.
- `fft_ready_out`  out  1  block accepts a beat; drive into the FFT's `m_axis_data_tready`.
- `peak_bin_out`  out  BIN_W  index of the strongest in-window bin.
- `peak_mag_out`  out  16  re²+im² of that bin, unsigned.
- `peak_valid_out`  out  1  one-cycle pulse when the `peak_*` outputs update.
- `note_on_out`  out  1  `peak_mag_out >= THRESH`; updates with `peak_valid_out`.
- `frame_err_out`  out  1  last frame ended at the wrong bin count; updates with `peak_valid_out`.

## Operation
- **Beat acceptance.** A beat is accepted on a rising edge where `fft_valid_in && fft_ready_out`.
- **Bin counter.**
  - `bin_cnt` (BIN_W bits) tags each accepted beat.
  - It increments per beat and clears to 0 at end of frame.
- **Pipeline.** 3 stages, advancing every cycle; a valid bit travels with the data.
  - S1: register re, im, bin tag and valid.
  - S2: register re² and im², 15 bits each, unsigned. (-128)² = 16384 is the maximum.
  - S3: register the 16-bit sum; the maximum 32768 fits.
- **Best tracking.** After S3, when the valid bit is set and `MIN_BIN <= tag <= MAX_BIN`:
  - If `sum > best_mag`, load `best_mag` and `best_bin`.
  - Comparison is strict, so ties keep the lowest bin.
- **End of frame.**
  - End of frame is an accepted beat with `fft_last_in=1`, or an accepted beat with `bin_cnt==NFFT-1` (whichever comes first).
  - `err_pend` is set if the two disagree: last arrives with `bin_cnt != NFFT-1`, or `bin_cnt` reaches NFFT-1 without last.
- **FSM.**
  - ACCUM: `fft_ready_out=1`. On end of frame, go to FLUSH.
  - FLUSH: `fft_ready_out=0`. Hold 3 cycles while the pipeline drains, then go to REPORT.
  - REPORT: `fft_ready_out=0`. Register outputs, pulse `peak_valid_out`, clear `best_mag` to 0, `best_bin` to `MIN_BIN`, `err_pend` to 0, then go to ACCUM.
- **No in-window energy.** If no in-window bin exceeded 0, report `peak_bin_out=MIN_BIN` and `peak_mag_out=0`.
- **Held outputs.** `peak_bin_out`, `peak_mag_out`, `note_on_out` and `frame_err_out` hold between reports.
- **Ready is registered.** `fft_ready_out` is registered from the next state.

## Timing
- **Reset values.**
  - While `rst_n_in=0`: all outputs are 0, state is ACCUM, all counters, pipeline valids and best registers are cleared.
  - `fft_ready_out` rises on the first clock edge after reset deasserts.
- **Reset mid-frame.** Partial results are discarded and nothing is reported. The next accepted beat is bin 0.
- **End-of-frame sequence.** Let cycle 0 be the cycle of the end-of-frame handshake.
  - Cycles 1–4: `fft_ready_out=0`.
  - Cycle 4: `peak_valid_out=1`, with new values on all `peak_*` outputs.
  - Cycle 5: `fft_ready_out=1`; the first beat of the next frame can be accepted.
- **Valid gaps.** Gaps in `fft_valid_in` during ACCUM are allowed; bubbles flow through the pipeline with valid=0.
- **Throughput.** One bin per cycle while in ACCUM. Per-frame overhead is 4 stall cycles.
- **Latency.** 4 cycles from the last handshake to `peak_valid_out`.

## Test plan
1. **Single tone.** 4096 beats, all zero except bin 440 = {im=8'sd0, re=8'sd100}, last on beat 4095 -> `peak_bin_out=440`, `peak_mag_out=10000`, `note_on_out=1`, `frame_err_out=0`, `peak_valid_out` pulse 4 cycles after the last handshake; `fft_ready_out` low exactly 4 cycles.
2. **Window and tie.**
   - Stimulus: bin 0 = {-128,-128}; bins 3000, 200 and 700 = {0,60}.
   - Response: `peak_bin_out=200`, `peak_mag_out=3600`. DC and out-of-window energy are ignored; the lower tied bin wins.
3. **Below threshold / silence.**
   - Bin 50 = {10,10} -> `peak_mag_out=200`, `note_on_out=0`.
   - All-zero frame -> `peak_bin_out=1`, `peak_mag_out=0`.
4. **Framing errors.**
   - Last asserted on beat 100 -> report with `frame_err_out=1`; the following correct frame reports `frame_err_out=0`.
   - 4096 beats without last -> report after beat 4095 with `frame_err_out=1`.
5. **Throttled input and mid-frame reset.**
   - Randomly gate `fft_valid_in` (50%) over a frame -> same result as scenario 1.
   - Assert `rst_n_in` low mid-frame for 2 cycles -> outputs 0 immediately, no `peak_valid_out`. A fresh 4096-beat frame then reports correctly.
